multiply_sequencer: RTL and testbench
=====================================

Name: multiply_sequencer

Overview:
Hardware controller that drives the Decoder/ALU datapath through an unsigned shift-and-add multiply, one instruction per clock. It latches two operands on Start, issues the load/mask/test/add/shift instruction stream on Instruction, and samples Flags and ALUBus to make decisions and collect the result. It returns the product on Product with a one-cycle Done pulse. It sits directly in front of the Decoder and is the sole source of its Instruction input.

Parameters:
WIDTH, 8, operand width in bits and loop iteration count; legal range 1..8, limited by the MOVI 8-bit immediate.
RA, 0, register index holding the multiplicand, shifted left each iteration.
RB, 1, register index holding the multiplier, shifted right each iteration.
RT, 2, scratch register for the LSB test; also the target of the idle instruction.
RP, 3, product accumulator register.

Ports:
Clock  in  1  system clock; all state updates on rising edge.
Reset  in  1  synchronous, active-high; same reset as Decoder.
Start  in  1  request pulse; sampled only in IDLE.
A  in  WIDTH  multiplicand, latched when Start is accepted.
B  in  WIDTH  multiplier, latched when Start is accepted.
Flags  in  5  Decoder flags; bit 4 = Z.
ALUBus  in  16  Decoder result bus.
Instruction  out  16  instruction to Decoder, format {op, dst, ext/immhi, src/immlo}.
Busy  out  1  high from the cycle after Start is accepted through the CAP state.
Done  out  1  one-cycle pulse when Product is valid.
Product  out  16  zero-extended 2*WIDTH-bit result; holds until the next Done.

Behaviour:
- Reset: state=IDLE, Busy=0, Done=0, Product=0, loop counter=0, operand latches=0.
- Instruction is a Moore decode of state, except COND, which also decodes registered Flags[4]. The Decoder executes the presented instruction at the rising edge that ends the cycle. Flags and ALUBus reflect that instruction during the following cycle.
- Idle instruction (IDLE and COND-skip): {Register, RT, MOV, RT}. It only affects flags.
- MOVI zero-extends its 8-bit immediate. A and B are zero-padded to 8 bits.
- States and issued instructions:
  - IDLE: idle instruction. Start=1 latches A and B, clears counter, goes to LDA.
  - LDA: {MOVI, RA, Ahi, Alo}, goes to LDB.
  - LDB: {MOVI, RB, Bhi, Blo}, goes to CLR.
  - CLR: {MOVI, RP, 0, 0}, goes to COPY.
  - COPY: {Register, RT, MOV, RB}, goes to MASK.
  - MASK: {ANDI, RT, 0, 1}, goes to TEST.
  - TEST: {Register, RT, MOV, RT}, goes to COND.
  - COND: if Flags[4]==0, issue {Register, RP, ADD, RA}; otherwise the idle instruction. Goes to SHA. COND always takes exactly one cycle, so latency is fixed.
  - SHA: {Shift, RA, LSH, 4'b0001}, goes to SHB.
  - SHB: {Shift, RB, LSH, 4'b1111} (logical right by 1). If counter==WIDTH-1, go to READ; otherwise increment counter and go to COPY.
  - READ: {Register, RP, MOV, RP}, goes to CAP.
  - CAP: idle instruction. At the closing edge: Product<=ALUBus, Done<=1, state->IDLE.
- Latency: 3 + 6*WIDTH + 2 states after the Start-accept edge. For WIDTH=8 that is 53 states, and Done is high in the cycle after the 53rd edge. Throughput is one multiply per 54 cycles if Start is held high.
- Start while Busy is ignored; no queueing. Start in the Done cycle is accepted (state is IDLE).
- Product is not altered while Busy; it changes only at the CAP edge.
- Register contents of RA, RB, RT and RP are destroyed by each operation.
- Reset mid-operation aborts immediately with reset values on the next edge; no partial Done.
- Overflow is impossible: 2*WIDTH <= 16.

Decomposition:
- Opcode, extension and register constants (MOVI, ANDI, Register, Shift, MOV, ADD, LSH, REG0-REG15) come from the shared instructionset.v include.
- Add an IDLE_INSTR constant there.
- State encodings are module-local localparams.
- No sub-module. Instruction assembly is a local function encode(op, dst, ext, src).

Test Plan:
- Reset, then Start with A=0x1F, B=0xE3 -> Busy for 53 cycles, Done pulse, Product=0x1B7D (7037).
- A=0xFF, B=0xFF -> Product=0xFE01. Also verify COND issued ADD on all 8 iterations.
- A=0x00, B=0xA5 and A=0x01, B=0x80 -> Product=0x0000 and 0x0080. Exactly one ADD is issued in the second case.
- Pulse Start again at cycle 20 of a run with different operands -> ignored; the first result is unchanged, and the next Start after Done yields the correct second product.
- Assert Reset at cycle 30 -> next cycle state=IDLE, Busy=0, Done=0, Product=0. A following Start with A=3, B=5 -> Product=15.
- Hold Start high continuously with A=2, B=7 -> back-to-back Done pulses every 54 cycles, each with Product=0x000E.

Source files
------------

// File: rtl/multiply_sequencer_pkg.sv
// multiply_sequencer_pkg: Decoder instruction-set constants shared by the sequencer and its environment.
package multiply_sequencer_pkg;
    localparam logic [3:0] REGISTER = 4'h0;
    localparam logic [3:0] MOVI     = 4'h1;
    localparam logic [3:0] ANDI     = 4'h2;
    localparam logic [3:0] SHIFT    = 4'h3;
    localparam logic [3:0] MOV      = 4'h0;
    localparam logic [3:0] ADD      = 4'h1;
    localparam logic [3:0] LSH      = 4'h0;
    localparam logic [3:0] REG0 = 4'd0, REG1 = 4'd1, REG2 = 4'd2, REG3 = 4'd3;
    localparam logic [3:0] REG4 = 4'd4, REG5 = 4'd5, REG6 = 4'd6, REG7 = 4'd7;
    localparam logic [3:0] REG8 = 4'd8, REG9 = 4'd9, REG10 = 4'd10, REG11 = 4'd11;
    localparam logic [3:0] REG12 = 4'd12, REG13 = 4'd13, REG14 = 4'd14, REG15 = 4'd15;
    // Flag-only no-op on the default scratch register.
    localparam logic [15:0] IDLE_INSTR = {REGISTER, REG2, MOV, REG2};
endpackage

// File: rtl/multiply_sequencer.sv
// multiply_sequencer: drives the Decoder/ALU through a shift-and-add unsigned multiply, one instruction per clock.
module multiply_sequencer
    import multiply_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RA    = 0,
    parameter int RB    = 1,
    parameter int RT    = 2,
    parameter int RP    = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Flags,
    input  logic [15:0]      ALUBus,
    output logic [15:0]      Instruction,
    output logic             Busy,
    output logic             Done,
    output logic [15:0]      Product
);
    typedef enum logic [3:0] {
        S_IDLE, S_LDA, S_LDB, S_CLR, S_COPY, S_MASK,
        S_TEST, S_COND, S_SHA, S_SHB, S_READ, S_CAP
    } state_e;

    localparam logic [3:0] RA4 = 4'(RA);
    localparam logic [3:0] RB4 = 4'(RB);
    localparam logic [3:0] RT4 = 4'(RT);
    localparam logic [3:0] RP4 = 4'(RP);

    function automatic logic [15:0] encode(input logic [3:0] op, input logic [3:0] dst,
                                           input logic [3:0] ext, input logic [3:0] src);
        return {op, dst, ext, src};
    endfunction

    localparam logic [15:0] IDLE_I = encode(REGISTER, RT4, MOV, RT4);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [15:0]      product_q, product_d;
    logic             done_q, done_d;
    logic [7:0]       a_imm, b_imm;
    logic             last;

    assign a_imm   = 8'(a_q);
    assign b_imm   = 8'(b_q);
    assign last    = cnt_q == 4'(WIDTH - 1);
    assign Busy    = state_q != S_IDLE;
    assign Done    = done_q;
    assign Product = product_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        product_d   = product_q;
        done_d      = 1'b0;
        Instruction = IDLE_I;
        case (state_q)
            S_IDLE: if (Start) begin
                a_d     = A;
                b_d     = B;
                cnt_d   = '0;
                state_d = S_LDA;
            end
            S_LDA: begin
                Instruction = encode(MOVI, RA4, a_imm[7:4], a_imm[3:0]);
                state_d     = S_LDB;
            end
            S_LDB: begin
                Instruction = encode(MOVI, RB4, b_imm[7:4], b_imm[3:0]);
                state_d     = S_CLR;
            end
            S_CLR: begin
                Instruction = encode(MOVI, RP4, 4'h0, 4'h0);
                state_d     = S_COPY;
            end
            S_COPY: begin
                Instruction = encode(REGISTER, RT4, MOV, RB4);
                state_d     = S_MASK;
            end
            S_MASK: begin
                Instruction = encode(ANDI, RT4, 4'h0, 4'h1);
                state_d     = S_TEST;
            end
            S_TEST: begin
                Instruction = encode(REGISTER, RT4, MOV, RT4);
                state_d     = S_COND;
            end
            // Z set means the multiplier LSB was zero: skip the add but keep the slot.
            S_COND: begin
                Instruction = Flags[4] ? IDLE_I : encode(REGISTER, RP4, ADD, RA4);
                state_d     = S_SHA;
            end
            S_SHA: begin
                Instruction = encode(SHIFT, RA4, LSH, 4'b0001);
                state_d     = S_SHB;
            end
            S_SHB: begin
                Instruction = encode(SHIFT, RB4, LSH, 4'b1111);
                state_d     = last ? S_READ : S_COPY;
                cnt_d       = last ? cnt_q : cnt_q + 4'd1;
            end
            S_READ: begin
                Instruction = encode(REGISTER, RP4, MOV, RP4);
                state_d     = S_CAP;
            end
            S_CAP: begin
                product_d = ALUBus;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_multiply_sequencer.sv
// tb_multiply_sequencer: random and directed multiplies against a behavioural Decoder and A*B reference.
module tb_multiply_sequencer;
    import multiply_sequencer_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [7:0]  A = '0, B = '0;
    logic [4:0]  Flags;
    logic [15:0] ALUBus;
    logic [15:0] Instruction;
    logic        Busy, Done;
    logic [15:0] Product;

    int checks = 0;
    int errors = 0;
    int total_adds = 0;
    logic [15:0] regs [16];

    multiply_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .A(A), .B(B),
        .Flags(Flags), .ALUBus(ALUBus), .Instruction(Instruction),
        .Busy(Busy), .Done(Done), .Product(Product)
    );

    always #5 Clock = ~Clock;

    // Behavioural Decoder: executes the presented instruction at the edge.
    always @(posedge Clock) begin
        logic [15:0] r;
        logic [3:0] op, d, e, s;
        {op, d, e, s} = Instruction;
        if (Reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            ALUBus <= '0;
            Flags  <= '0;
        end else begin
            if (op == MOVI) r = {8'h00, e, s};
            else if (op == ANDI) r = regs[d] & {8'h00, e, s};
            else if (op == SHIFT) r = $signed(s) >= 0 ? regs[d] << s : regs[d] >> (-$signed(s));
            else r = (e == ADD) ? regs[d] + regs[s] : regs[s];
            regs[d] <= r;
            ALUBus  <= r;
            Flags   <= {r == 16'h0, 4'b0};
            if (Instruction == {REGISTER, REG3, ADD, REG0}) total_adds++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit poke);
        int n = 0, k = 0, base;
        bit held = 1'b1;
        logic [15:0] prev = Product;
        base = total_adds;
        A = a; B = b; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        while (k < 200) begin
            if (Busy) n++;
            if (Product !== prev) held = 1'b0;
            if (poke && k == 20) begin A = ~a; B = b + 8'd1; Start = 1'b1; end
            else Start = 1'b0;
            @(negedge Clock);
            k++;
            if (Done) break;
        end
        Start = 1'b0;
        check("latency", k, 53);
        check("busy_cycles", n, 53);
        check("product_held", held, 1);
        check("product", Product, 32'(a) * 32'(b));
        check("add_count", total_adds - base, $countones(b));
        @(negedge Clock);
        check("done_pulse", Done, 0);
        check("product_stays", Product, 32'(a) * 32'(b));
    endtask

    initial begin
        int k, pulses, last_k;
        repeat (3) @(negedge Clock);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_product", Product, 0);
        check("rst_instr", Instruction, IDLE_INSTR);
        Reset = 1'b0;
        @(negedge Clock);
        do_op(8'h1F, 8'hE3, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0);
        do_op(8'h00, 8'hA5, 1'b0);
        do_op(8'h01, 8'h80, 1'b0);
        do_op(8'h6B, 8'h39, 1'b1);
        do_op(8'h12, 8'hC4, 1'b0);
        for (int i = 0; i < 8; i++) do_op(8'($urandom), 8'($urandom), i == 3);
        // Abort mid-operation.
        A = 8'h55; B = 8'h33; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (29) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("abort_busy", Busy, 0);
        check("abort_done", Done, 0);
        check("abort_product", Product, 0);
        check("abort_instr", Instruction, IDLE_INSTR);
        Reset = 1'b0;
        @(negedge Clock);
        do_op(8'd3, 8'd5, 1'b0);
        // Start held high: back-to-back operations.
        A = 8'd2; B = 8'd7; Start = 1'b1;
        k = 0; pulses = 0; last_k = 0;
        while (k < 400 && pulses < 3) begin
            @(negedge Clock);
            k++;
            if (Done) begin
                if (pulses > 0) check("b2b_gap", k - last_k, 54);
                check("b2b_product", Product, 16'h000E);
                pulses++;
                last_k = k;
            end
        end
        Start = 1'b0;
        check("b2b_pulses", pulses, 3);
        repeat (60) @(negedge Clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
